led_dec_multi: RTL and testbench
================================

LED_DEC_MULTI -- requirements
Module: led_dec_multi

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of hex digits driven (legal range 1..8).
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 1, where 1 means a segment is lit when its bit is 0, and 0 inverts every segment bit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, 4*NUM_DIGITS bits: hex word; digit i is data_in[4i+3:4i], digit 0 least significant.
REQ-006 The block SHALL have port valid_in, input, 1 bit: data_in is offered this cycle.
REQ-007 The block SHALL have port ready_out, output, 1 bit: the block accepts data_in this cycle.
REQ-008 The block SHALL have port segments_out, output, 7*NUM_DIGITS bits: digit i pattern at [7i+6:7i], bit order {g,f,e,d,c,b,a}.
REQ-009 The block SHALL have port update_out, output, 1 bit: one-cycle pulse when segments_out takes a new frame.

Function
REQ-010 A word SHALL be accepted on a rising edge where valid_in=1 and ready_out=1; valid_in while ready_out=0 SHALL be ignored and that word dropped.
REQ-011 Two states: IDLE (ready_out=1) and DECODE (ready_out=0); acceptance SHALL move IDLE->DECODE and capture data_in into an internal latch.
REQ-012 DECODE SHALL use one shared 4-to-7 decoder, converting one digit per cycle from digit NUM_DIGITS-1 down to digit 0, into a shadow register.
REQ-013 ACTIVE_LOW=1 patterns, hex: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 B=03 C=27 D=21 E=06 F=0E; blank=7F; ACTIVE_LOW=0 SHALL output the bitwise inverse of each.
REQ-014 On the edge that decodes digit 0, segments_out SHALL load the full shadow, including digit 0, atomically; update_out SHALL be 1 for the following cycle only; state SHALL return to IDLE.
REQ-015 Timing: accepted at edge T -> ready_out=0 for cycles T+1..T+NUM_DIGITS-1; new segments_out, update_out=1 and ready_out=1 all visible after edge T+NUM_DIGITS.
REQ-016 With NUM_DIGITS=1, ready_out SHALL never drop; every accepted word SHALL update after one edge.
REQ-017 segments_out SHALL hold its previous frame throughout DECODE and never show a partially updated frame.
REQ-018 A word offered with valid_in=1 in the same cycle that DECODE completes SHALL be accepted on the next edge, because ready_out is 1 then.

Reset
REQ-019 While reset=1 at a rising edge: state=IDLE, ready_out=1, update_out=0, segments_out all digits blank (7F each if ACTIVE_LOW=1, 00 if 0); latch and shadow cleared.
REQ-020 Reset asserted mid-DECODE SHALL abort the frame; no update_out pulse; the partial shadow SHALL never reach segments_out.
REQ-021 Reset SHALL take priority over a simultaneous valid_in.

Configuration
REQ-022 Macro LED_DEC_LZ_SUPPRESS_EN defined: during DECODE, each digit that is 0 and has only zero digits above it SHALL decode as blank; digit 0 SHALL never be blanked.
REQ-023 Macro LED_DEC_LZ_SUPPRESS_EN undefined: every digit SHALL decode per REQ-013; no suppression logic SHALL be present; timing is identical in both builds.

Verification (NUM_DIGITS=4, ACTIVE_LOW=1)
REQ-024 Reset, then idle -> segments_out=7F7F7F7F per digit, ready_out=1, update_out=0.
REQ-025 valid_in=1 with data_in=16'h1A2F at edge T -> ready_out=0 cycles T+1..T+3; after T+4 digits 3..0 = 79,08,24,0E, update_out one-cycle pulse.
REQ-026 valid_in held 1 with data_in=16'h5555 during DECODE of 16'h1234 -> 1234 shown; 5555 accepted only when ready_out returns, then shown 4 edges later.
REQ-027 reset pulsed at T+2 mid-DECODE of 16'h8888 -> segments_out blank, no update_out pulse, next word decodes normally.
REQ-028 LED_DEC_LZ_SUPPRESS_EN defined: 16'h0070 -> digits 3..0 = 7F,7F,78,40; 16'h0000 -> 7F,7F,7F,40; undefined: 16'h0070 -> 40,40,78,40.
REQ-029 Back-to-back words 16'hFFFF then 16'h0000 offered each cycle -> exactly two update_out pulses, 4 cycles apart, frames F F F F then 0 0 0 0.

Source files
------------

// File: rtl/led_dec_multi.sv
//------------------------------------------------------------------------------
// led_dec_multi
//
// Multi-digit hex to 7-segment decoder that shares one 4-to-7 decoder across
// all digits. An accepted word is latched, then decoded one digit per clock,
// most significant digit first, into a shadow frame. The completed frame is
// copied to segments_out in a single edge, so the display never shows a
// partially updated frame.
//
// Parameters:
//   NUM_DIGITS  number of hex digits driven (1..8)
//   ACTIVE_LOW  1: a segment is lit when its bit is 0; 0: all bits inverted
//
// Optional build macro:
//   LED_DEC_LZ_SUPPRESS_EN  when defined, leading zero digits decode as
//                           blank (digit 0 is never blanked)
//
// Ports:
//   clk           single clock, rising edge
//   reset         synchronous active-high reset
//   data_in       hex word, digit i at [4i+3:4i]
//   valid_in      data_in offered this cycle
//   ready_out     block accepts data_in this cycle
//   segments_out  digit i pattern at [7i+6:7i], bit order {g,f,e,d,c,b,a}
//   update_out    one-cycle pulse when segments_out takes a new frame
//------------------------------------------------------------------------------
module led_dec_multi #(
    parameter int NUM_DIGITS = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [7*NUM_DIGITS-1:0] segments_out,
    output logic                    update_out
);

    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_DIGITS - 1);
    localparam logic [6:0] BLANK_PAT = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [7*NUM_DIGITS-1:0] BLANK_FRAME = {NUM_DIGITS{BLANK_PAT}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_DECODE = 1'b1
    } state_t;

    // Hex nibble to segment pattern, polarity applied.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h18;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h27;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        if (ACTIVE_LOW != 0) begin
            return pat;
        end else begin
            return ~pat;
        end
    endfunction

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;       // index of the digit decoded on the next edge
    logic [4*NUM_DIGITS-1:0] r_latch;
    logic [7*NUM_DIGITS-1:0] r_shadow;
    logic [7*NUM_DIGITS-1:0] r_segments;
    logic                    r_update;
    logic                    r_ready;
`ifdef LED_DEC_LZ_SUPPRESS_EN
    logic                    r_lz;        // every digit decoded so far was zero
`endif

    logic [3:0]              w_nib;
    logic [6:0]              w_pat;
    logic [7*NUM_DIGITS-1:0] w_frame;

    // Shared decoder: pattern for the current digit and the frame it completes.
    always_comb begin
        w_nib = r_latch[4*int'(r_cnt) +: 4];
`ifdef LED_DEC_LZ_SUPPRESS_EN
        if (r_lz && (w_nib == 4'h0) && (r_cnt != {CW{1'b0}})) begin
            w_pat = BLANK_PAT;
        end else begin
            w_pat = hex_to_seg(w_nib);
        end
`else
        w_pat = hex_to_seg(w_nib);
`endif
        w_frame        = r_shadow;
        w_frame[6:0]   = w_pat;
    end

    // Control FSM, shadow fill, atomic frame load and registered handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {CW{1'b0}};
            r_latch    <= {(4*NUM_DIGITS){1'b0}};
            r_shadow   <= {(7*NUM_DIGITS){1'b0}};
            r_segments <= BLANK_FRAME;
            r_update   <= 1'b0;
            r_ready    <= 1'b1;
`ifdef LED_DEC_LZ_SUPPRESS_EN
            r_lz       <= 1'b0;
`endif
        end else begin
            r_update <= 1'b0;

            if (r_state == ST_DECODE) begin
                r_shadow[7*int'(r_cnt) +: 7] <= w_pat;
`ifdef LED_DEC_LZ_SUPPRESS_EN
                r_lz <= r_lz && (w_nib == 4'h0);
`endif
                if (r_cnt == {CW{1'b0}}) begin
                    r_segments <= w_frame;
                    r_update   <= 1'b1;
                    r_state    <= ST_IDLE;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end else begin
                r_state <= ST_IDLE;
            end

            // Ready is already high during the last decode cycle, so a new
            // word can be accepted on the same edge that finishes the frame.
            // A later acceptance overrides the state/counter written above.
            if (valid_in && r_ready) begin
                r_latch <= data_in;
                r_state <= ST_DECODE;
                r_cnt   <= LAST_IDX;
                r_ready <= (NUM_DIGITS == 1);
`ifdef LED_DEC_LZ_SUPPRESS_EN
                r_lz    <= 1'b1;
`endif
            end else if ((r_state == ST_DECODE) && (r_cnt != {CW{1'b0}})) begin
                r_ready <= (r_cnt == CW'(1));
            end else begin
                r_ready <= 1'b1;
            end
        end
    end

    assign ready_out    = r_ready;
    assign segments_out = r_segments;
    assign update_out   = r_update;

endmodule

// File: tb/tb_led_dec_multi.sv
//------------------------------------------------------------------------------
// tb_led_dec_multi
//
// Drives led_dec_multi (NUM_DIGITS=4, ACTIVE_LOW=1) with directed and random
// words and compares every cycle against a transaction-level model: a word
// accepted at edge T shows its full frame after edge T+4, and the block is
// ready whenever nothing is in flight or the in-flight word completes on the
// next edge.
//------------------------------------------------------------------------------
module tb_led_dec_multi;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   data_in;
    logic          valid_in;
    logic          ready_out;
    logic [27:0]   segments_out;
    logic          update_out;

    led_dec_multi #(.NUM_DIGITS(N), .ACTIVE_LOW(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .segments_out (segments_out),
        .update_out   (update_out)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;

    // model state
    logic        m_busy  = 1'b0;
    int          m_left  = 0;
    logic [15:0] m_word  = 16'h0;
    logic [27:0] m_seg   = {4{7'h7F}};
    logic        m_upd   = 1'b0;
    logic        m_ready = 1'b1;

    function automatic logic [27:0] expect_frame(input logic [15:0] w);
        logic [27:0] f;
        logic        lead;
        logic [3:0]  nib;
        f    = 28'h0;
        lead = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            nib = w[4*i +: 4];
`ifdef LED_DEC_LZ_SUPPRESS_EN
            if (lead && nib == 4'h0 && i != 0) begin
                f[7*i +: 7] = 7'h7F;
            end else begin
                lead = 1'b0;
                f[7*i +: 7] = seg_tbl[nib];
            end
`else
            lead = 1'b0;
            f[7*i +: 7] = seg_tbl[nib];
`endif
        end
        return f;
    endfunction

    task automatic model_edge(input logic v, input logic [15:0] d, input logic r);
        logic acc;
        if (r) begin
            m_busy  = 1'b0;
            m_left  = 0;
            m_seg   = {4{7'h7F}};
            m_upd   = 1'b0;
            m_ready = 1'b1;
        end else begin
            acc   = v && m_ready;
            m_upd = 1'b0;
            if (m_busy && m_left == 1) begin
                m_seg  = expect_frame(m_word);
                m_upd  = 1'b1;
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_left = m_left - 1;
            end
            if (acc) begin
                m_word = d;
                m_busy = 1'b1;
                m_left = N;
            end
            m_ready = !m_busy || (m_left == 1);
        end
    endtask

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("ready", {27'h0, ready_out}, {27'h0, m_ready});
        check("update", {27'h0, update_out}, {27'h0, m_upd});
        check("segments", segments_out, m_seg);
        if (update_out === 1'b1) pulses++;
    endtask

    // One clock: drive inputs, apply the edge to the model, compare on negedge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic r);
        valid_in = v;
        data_in  = d;
        reset    = r;
        @(posedge clk);
        model_edge(v, d, r);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        valid_in = 1'b0;
        data_in  = 16'h0;
        reset    = 1'b1;

        // reset then idle
        repeat (3) cycle(1'b0, 16'h0, 1'b1);
        repeat (2) cycle(1'b0, 16'h0, 1'b0);
        check("pin_rst_seg", segments_out, {4{7'h7F}});
        check("pin_rst_ready", {27'h0, ready_out}, 28'h1);
        check("pin_rst_upd", {27'h0, update_out}, 28'h0);

        // 1A2F: ready low for three cycles, frame after fourth edge
        cycle(1'b1, 16'h1A2F, 1'b0);
        check("pin_busy0", {27'h0, ready_out}, 28'h0);
        cycle(1'b0, 16'h0, 1'b0);
        check("pin_busy1", {27'h0, ready_out}, 28'h0);
        cycle(1'b0, 16'h0, 1'b0);
        check("pin_busy2", {27'h0, ready_out}, 28'h0);
        cycle(1'b0, 16'h0, 1'b0);
        check("pin_hold_seg", segments_out, {4{7'h7F}});
        cycle(1'b0, 16'h0, 1'b0);
        check("pin_1a2f", segments_out, {7'h79, 7'h08, 7'h24, 7'h0E});
        check("pin_1a2f_upd", {27'h0, update_out}, 28'h1);
        cycle(1'b0, 16'h0, 1'b0);
        check("pin_upd_low", {27'h0, update_out}, 28'h0);

        // 5555 held during decode of 1234
        cycle(1'b1, 16'h1234, 1'b0);
        repeat (3) cycle(1'b1, 16'h5555, 1'b0);
        cycle(1'b1, 16'h5555, 1'b0);
        check("pin_1234", segments_out, {7'h79, 7'h24, 7'h30, 7'h19});
        repeat (3) cycle(1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        check("pin_5555", segments_out, {4{7'h12}});

        // reset mid-decode of 8888
        cycle(1'b1, 16'h8888, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        cycle(1'b1, 16'h4444, 1'b1);
        pulses = 0;
        repeat (5) cycle(1'b0, 16'h0, 1'b0);
        check("pin_abort_seg", segments_out, {4{7'h7F}});
        check("pin_abort_pulses", 28'(pulses), 28'h0);
        cycle(1'b1, 16'h1A2F, 1'b0);
        repeat (4) cycle(1'b0, 16'h0, 1'b0);
        check("pin_after_abort", segments_out, {7'h79, 7'h08, 7'h24, 7'h0E});

        // back-to-back FFFF then 0000
        pulses = 0;
        cycle(1'b1, 16'hFFFF, 1'b0);
        repeat (3) cycle(1'b1, 16'h0000, 1'b0);
        cycle(1'b1, 16'h0000, 1'b0);
        check("pin_ffff", segments_out, {4{7'h0E}});
        repeat (3) cycle(1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
`ifdef LED_DEC_LZ_SUPPRESS_EN
        check("pin_0000", segments_out, {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
        check("pin_0000", segments_out, {4{7'h40}});
`endif
        repeat (3) cycle(1'b0, 16'h0, 1'b0);
        check("pin_b2b_pulses", 28'(pulses), 28'h2);

        // 0070 leading-zero behaviour
        cycle(1'b1, 16'h0070, 1'b0);
        repeat (4) cycle(1'b0, 16'h0, 1'b0);
`ifdef LED_DEC_LZ_SUPPRESS_EN
        check("pin_0070", segments_out, {7'h7F, 7'h7F, 7'h78, 7'h40});
`else
        check("pin_0070", segments_out, {7'h40, 7'h40, 7'h78, 7'h40});
`endif

        // random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = d & 16'h00FF;
            if ($urandom_range(0, 7) == 0) d = 16'h0;
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 63) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
